shaping_peak_detect: RTL and testbench

//  Consumer of the trapezoidal shaper output. Qualifies pulses on the shaped
//  14-bit stream against a threshold with hysteresis and finds each pulse's

---
 rtl/shaping_peak_detect.sv | 211 +++++++++++++++++++++
 tb/tb_shaping_peak_detect.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shaping_peak_detect.sv
// Pulse qualifier for the shaped stream: hysteresis thresholding, peak capture,
// pileup/timeout flagging and a single-slot valid/ready event output.
module shaping_peak_detect #(
    parameter int unsigned HYST   = 16,
    parameter int unsigned MAXLEN = 1024,
    parameter int unsigned TSW    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic signed [13:0]    i_shaped,
    input  logic                  i_en,
    input  logic signed [13:0]    i_thresh,
    input  logic        [11:0]    i_holdoff,
    output logic                  o_peak_valid,
    input  logic                  i_peak_ready,
    output logic signed [13:0]    o_peak_height,
    output logic        [TSW-1:0] o_peak_time,
    output logic        [1:0]     o_peak_flags,
    output logic        [15:0]    o_drop_cnt,
    output logic                  o_busy
);

    localparam int unsigned         LW       = $clog2(MAXLEN + 1);
    localparam logic [LW-1:0]       LEN_LAST = LW'(MAXLEN - 1);
    localparam logic signed [14:0]  HYST15   = 15'(HYST);

    typedef enum logic [1:0] {
        StIdle,
        StRise,
        StFall,
        StDead
    } state_t;

    // Sample pipeline and free-running timestamp
    logic signed [13:0] r_s;
    logic [TSW-1:0]     r_ts;

    // Pulse tracking state
    state_t             r_state, w_state_d;
    logic signed [13:0] r_max, w_max_d;
    logic [TSW-1:0]     r_tmax, w_tmax_d;
    logic signed [13:0] r_fmin, w_fmin_d;
    logic [LW-1:0]      r_len, w_len_d;
    logic               r_pile, w_pile_d;
    logic [11:0]        r_dead, w_dead_d;

    // Output slot
    logic               r_valid;
    logic signed [13:0] r_height;
    logic [TSW-1:0]     r_time;
    logic [1:0]         r_flags;
    logic [15:0]        r_drop;

    logic               w_emit;
    logic               w_timeout;
    logic               w_pulse_end;

    // Thresholds are widened to 15 bits so thresh-HYST cannot wrap.
    logic signed [14:0] w_hi;
    logic signed [14:0] w_lo;
    logic signed [14:0] w_s_ext;
    logic signed [14:0] w_fmin_ext;
    logic signed [14:0] w_fmin_hyst;

    assign w_hi        = {i_thresh[13], i_thresh};
    assign w_lo        = w_hi - HYST15;
    assign w_s_ext     = {r_s[13], r_s};
    assign w_fmin_ext  = {r_fmin[13], r_fmin};
    assign w_fmin_hyst = w_fmin_ext + HYST15;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s  <= '0;
            r_ts <= '0;
        end else begin
            r_s  <= i_shaped;
            r_ts <= r_ts + TSW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_max   <= '0;
            r_tmax  <= '0;
            r_fmin  <= '0;
            r_len   <= '0;
            r_pile  <= 1'b0;
            r_dead  <= '0;
        end else begin
            r_state <= w_state_d;
            r_max   <= w_max_d;
            r_tmax  <= w_tmax_d;
            r_fmin  <= w_fmin_d;
            r_len   <= w_len_d;
            r_pile  <= w_pile_d;
            r_dead  <= w_dead_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_max_d     = r_max;
        w_tmax_d    = r_tmax;
        w_fmin_d    = r_fmin;
        w_len_d     = r_len;
        w_pile_d    = r_pile;
        w_dead_d    = r_dead;
        w_emit      = 1'b0;
        w_timeout   = 1'b0;
        w_pulse_end = 1'b0;

        if (!i_en) begin
            // Disabling abandons any in-flight pulse; the output slot is untouched.
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_s_ext > w_hi) begin
                        w_state_d = StRise;
                        w_max_d   = r_s;
                        w_tmax_d  = r_ts;
                        w_len_d   = '0;
                        w_pile_d  = 1'b0;
                    end
                end
                StRise: begin
                    // Strictly greater keeps the first sample of a flat top.
                    if (r_s > r_max) begin
                        w_max_d  = r_s;
                        w_tmax_d = r_ts;
                    end else if (r_s < r_max) begin
                        w_state_d = StFall;
                        w_fmin_d  = r_s;
                    end
                end
                StFall: begin
                    if (r_s < r_fmin) begin
                        w_fmin_d = r_s;
                    end
                    if (w_s_ext > w_fmin_hyst) begin
                        w_pile_d = 1'b1;
                    end
                    if (w_s_ext < w_lo) begin
                        w_pulse_end = 1'b1;
                    end
                end
                StDead: begin
                    if (r_dead <= 12'd1) begin
                        w_state_d = StIdle;
                    end else begin
                        w_dead_d = r_dead - 12'd1;
                    end
                end
                default: w_state_d = StIdle;
            endcase

            if (r_state == StRise || r_state == StFall) begin
                if (w_pulse_end) begin
                    w_emit = 1'b1;
                end else if (r_len == LEN_LAST) begin
                    w_emit    = 1'b1;
                    w_timeout = 1'b1;
                end else begin
                    w_len_d = r_len + LW'(1);
                end

                if (w_emit) begin
                    if (i_holdoff != 12'd0) begin
                        w_state_d = StDead;
                        w_dead_d  = i_holdoff;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
        end
    end

    // Single-slot output: a held event wins over a new one unless it is taken this cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid  <= 1'b0;
            r_height <= '0;
            r_time   <= '0;
            r_flags  <= '0;
            r_drop   <= '0;
        end else if (w_emit) begin
            if (r_valid && !i_peak_ready) begin
                if (r_drop != 16'hFFFF) begin
                    r_drop <= r_drop + 16'd1;
                end
            end else begin
                r_valid  <= 1'b1;
                r_height <= w_max_d;
                r_time   <= w_tmax_d;
                r_flags  <= {w_pile_d, w_timeout};
            end
        end else if (r_valid && i_peak_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_peak_valid  = r_valid;
    assign o_peak_height = r_height;
    assign o_peak_time   = r_time;
    assign o_peak_flags  = r_flags;
    assign o_drop_cnt    = r_drop;
    assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_shaping_peak_detect.sv
// Scoreboard bench for shaping_peak_detect: a scan-based pulse model predicts
// the events and their acceptance edges; a monitor checks each handshake.
module tb_shaping_peak_detect;

    localparam int HYST   = 16;
    localparam int MAXLEN = 1024;
    localparam int NMAX   = 4000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [13:0] shaped = '0;
    logic               en = 1'b0;
    logic signed [13:0] thresh = '0;
    logic        [11:0] holdoff = '0;
    logic               ready = 1'b0;
    logic               o_peak_valid;
    logic signed [13:0] o_peak_height;
    logic        [15:0] o_peak_time;
    logic        [1:0]  o_peak_flags;
    logic        [15:0] o_drop_cnt;
    logic               o_busy;

    always #5 clk = ~clk;

    shaping_peak_detect #(
        .HYST   (HYST),
        .MAXLEN (MAXLEN),
        .TSW    (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_shaped      (shaped),
        .i_en          (en),
        .i_thresh      (thresh),
        .i_holdoff     (holdoff),
        .o_peak_valid  (o_peak_valid),
        .i_peak_ready  (ready),
        .o_peak_height (o_peak_height),
        .o_peak_time   (o_peak_time),
        .o_peak_flags  (o_peak_flags),
        .o_drop_cnt    (o_drop_cnt),
        .o_busy        (o_busy)
    );

    typedef struct {
        int height;
        int tstamp;
        int flags;
        int acc_edge;
    } ev_t;

    int   samp [NMAX];
    bit   en_a [NMAX];
    bit   rdy_a[NMAX];
    int   nlen;
    int   thr;
    int   hold;
    bit   rdy_def;
    ev_t  exp_q[$];
    int   exp_drops;
    bit   exp_valid_end;
    int   tests = 0;
    int   fails = 0;
    int   ec;

    // Edge index since reset release; DUT timestamp tracks this value.
    always @(posedge clk or posedge rst) begin
        if (rst) ec <= 0;
        else     ec <= ec + 1;
    end

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_peak_valid && ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_event", int'(o_peak_valid), 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("height", int'(o_peak_height), e.height);
                check("time", int'(o_peak_time), e.tstamp);
                check("flags", int'(o_peak_flags), e.flags);
                check("accept_edge", ec + 1, e.acc_edge);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Sample seen by the detector at edge e (captured one edge earlier).
    function automatic int sv(int e);
        return (e <= 1) ? 0 : samp[e-1];
    endfunction

    task automatic put(int v, bit e_in, bit r_in);
        if (v > 8191)  v = 8191;
        if (v < -8192) v = -8192;
        nlen++;
        samp[nlen]  = v;
        en_a[nlen]  = e_in;
        rdy_a[nlen] = r_in;
    endtask

    task automatic put_d(int v);
        put(v, 1'b1, rdy_def);
    endtask

    // n samples from a (exclusive) to b (inclusive); rnd randomises en/ready.
    task automatic ramp(int a, int b, int n, bit rnd);
        for (int i = 1; i <= n; i++) begin
            if (rnd) put(a + (b - a) * i / n, ($urandom % 60) != 0, ($urandom % 4) != 0);
            else     put_d(a + (b - a) * i / n);
        end
    endtask

    task automatic tail();
        rdy_def = 1'b1;
        repeat (40) put_d(0);
    endtask

    task automatic build_expected();
        ev_t evs[$];
        ev_t ev, cur;
        int  pos, e0, e, v, peak, tpk, fmin, lo, idx;
        bit  rising, pile, done, fin, tmo, vld;
        lo = thr - HYST;
        exp_q.delete();
        exp_drops = 0;
        pos = 1;
        while (pos <= nlen) begin
            if (!en_a[pos] || sv(pos) <= thr) begin
                pos++;
                continue;
            end
            e0 = pos; peak = sv(e0); tpk = e0 - 1;
            rising = 1; pile = 0; fmin = 0; done = 0;
            e = e0 + 1;
            while (!done && e <= nlen) begin
                v = sv(e);
                if (!en_a[e]) begin
                    done = 1;
                    pos  = e + 1;
                end else begin
                    fin = 0; tmo = 0;
                    if (rising) begin
                        if (v > peak) begin peak = v; tpk = e - 1; end
                        else if (v < peak) begin rising = 0; fmin = v; end
                    end else begin
                        if (v > fmin + HYST) pile = 1;
                        if (v < fmin) fmin = v;
                        if (v < lo) fin = 1;
                    end
                    if (!fin && (e - e0 - 1) == MAXLEN - 1) tmo = 1;
                    if (fin || tmo) begin
                        ev.height   = peak;
                        ev.tstamp   = tpk & 16'hFFFF;
                        ev.flags    = (pile ? 2 : 0) + (tmo ? 1 : 0);
                        ev.acc_edge = e;
                        evs.push_back(ev);
                        done = 1;
                        pos  = e + hold + 1;
                        for (int d = e + 1; d <= e + hold; d++) begin
                            if (d <= nlen && !en_a[d]) begin
                                pos = d + 1;
                                break;
                            end
                        end
                    end else begin
                        e++;
                    end
                end
            end
            if (!done) pos = nlen + 1;
        end

        vld = 0; idx = 0;
        for (int k = 1; k <= nlen; k++) begin
            if (vld && rdy_a[k]) begin
                cur.acc_edge = k;
                exp_q.push_back(cur);
            end
            if (idx < evs.size() && evs[idx].acc_edge == k) begin
                if (vld && !rdy_a[k]) exp_drops++;
                else begin cur = evs[idx]; vld = 1; end
                idx++;
            end else if (vld && rdy_a[k]) begin
                vld = 0;
            end
        end
        exp_valid_end = vld;
    endtask

    task automatic drive(int e);
        shaped = 14'(samp[e]);
        en     = en_a[e];
        ready  = rdy_a[e];
    endtask

    task automatic run_phase(bit exp_busy);
        build_expected();
        rst = 1'b1; shaped = '0; en = 1'b0; ready = 1'b0;
        thresh = 14'(thr); holdoff = 12'(hold);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(o_peak_valid), 0);
        check("rst_height", int'(o_peak_height), 0);
        check("rst_time", int'(o_peak_time), 0);
        check("rst_flags", int'(o_peak_flags), 0);
        check("rst_drop", int'(o_drop_cnt), 0);
        check("rst_busy", int'(o_busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1);
        for (int e = 1; e <= nlen; e++) begin
            @(posedge clk); #1;
            if (e < nlen) drive(e + 1);
        end
        ready = 1'b0; en = 1'b0;
        check("end_pending", exp_q.size(), 0);
        check("drop_cnt", int'(o_drop_cnt), exp_drops);
        check("end_valid", int'(o_peak_valid), int'(exp_valid_end));
        check("end_busy", int'(o_busy), int'(exp_busy));
    endtask

    task automatic clear(int t, int h);
        nlen = 0; thr = t; hold = h; rdy_def = 1'b1;
    endtask

    task automatic random_pulses(int np);
        int base, peak, mid;
        for (int p = 0; p < np; p++) begin
            base = int'($urandom_range(0, 60)) - 30;
            ramp(base, base, int'($urandom_range(1, 10)), 1'b1);
            peak = int'($urandom_range(0, 2500)) - 200;
            ramp(base, peak, int'($urandom_range(1, 8)), 1'b1);
            ramp(peak, peak, int'($urandom_range(1, 3)), 1'b1);
            if ($urandom % 3 == 0) begin
                mid = peak / 2;
                ramp(peak, mid, int'($urandom_range(1, 5)), 1'b1);
                ramp(mid, mid + int'($urandom_range(0, 60)), int'($urandom_range(1, 3)), 1'b1);
                ramp(mid, base, int'($urandom_range(1, 8)), 1'b1);
            end else begin
                ramp(peak, base, int'($urandom_range(1, 8)), 1'b1);
            end
        end
    endtask

    initial begin
        // Triangle 0->500->0
        clear(100, 0);
        repeat (5) put_d(0);
        ramp(0, 500, 10, 1'b0);
        ramp(500, 0, 10, 1'b0);
        tail();
        run_phase(1'b0);

        // Reset asserted mid-rise by the next phase
        clear(100, 0);
        repeat (3) put_d(0);
        ramp(0, 450, 3, 1'b0);
        run_phase(1'b1);

        // Flat top of 300
        clear(100, 3);
        repeat (4) put_d(0);
        ramp(0, 300, 3, 1'b0);
        repeat (9) put_d(300);
        ramp(300, 0, 3, 1'b0);
        tail();
        run_phase(1'b0);

        // Pileup bump
        clear(100, 0);
        repeat (4) put_d(0);
        ramp(0, 400, 2, 1'b0);
        ramp(400, 200, 2, 1'b0);
        ramp(200, 350, 2, 1'b0);
        ramp(350, 0, 4, 1'b0);
        tail();
        run_phase(1'b0);

        // Timeout on a held level
        clear(100, 5);
        repeat (4) put_d(0);
        repeat (1100) put_d(1000);
        tail();
        run_phase(1'b0);

        // Backpressure: three pulses with ready low
        clear(100, 0);
        rdy_def = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            repeat (4) put_d(0);
            ramp(0, 200 + 100 * p, 4, 1'b0);
            ramp(200 + 100 * p, 0, 4, 1'b0);
        end
        tail();
        run_phase(1'b0);

        // Enable dropped mid-fall, then a normal pulse
        clear(100, 2);
        repeat (4) put_d(0);
        ramp(0, 400, 4, 1'b0);
        ramp(400, 250, 3, 1'b0);
        for (int i = 1; i <= 6; i++) put(250 - 50 * i, 1'b0, 1'b1);
        repeat (4) put_d(0);
        ramp(0, 600, 4, 1'b0);
        ramp(600, 0, 4, 1'b0);
        tail();
        run_phase(1'b0);

        // Randomised pulse trains
        clear(100, int'($urandom_range(0, 20)));
        random_pulses(30);
        tail();
        run_phase(1'b0);

        clear(40, int'($urandom_range(0, 20)));
        random_pulses(30);
        tail();
        run_phase(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
